// File: rtl/mips_mmio_pkg.sv
// Shared address map and target decode for the MIPS data-side memory responder.
package mips_mmio_pkg;

  localparam logic [15:0] MMIO_HI = 16'hFFFF;

  localparam logic [7:0] OFS_LED  = 8'h00;
  localparam logic [7:0] OFS_SW   = 8'h04;
  localparam logic [7:0] OFS_CYC  = 8'h08;
  localparam logic [7:0] OFS_TXD  = 8'h0C;
  localparam logic [7:0] OFS_TXS  = 8'h10;
  localparam logic [7:0] OFS_DROP = 8'h14;

  typedef enum logic [2:0] {
    T_RAM,
    T_LED,
    T_SW,
    T_CYC,
    T_TXD,
    T_TXS,
    T_DROP,
    T_NONE
  } mmio_target_e;

  // ofs is the word-aligned MMIO offset; the byte-lane bits are already cleared.
  function automatic mmio_target_e decode_target(logic [15:0] hi, logic [7:0] ofs);
    mmio_target_e t;
    if (hi != MMIO_HI) begin
      t = T_RAM;
    end else begin
      case (ofs)
        OFS_LED:  t = T_LED;
        OFS_SW:   t = T_SW;
        OFS_CYC:  t = T_CYC;
        OFS_TXD:  t = T_TXD;
        OFS_TXS:  t = T_TXS;
        OFS_DROP: t = T_DROP;
        default:  t = T_NONE;
      endcase
    end
    return t;
  endfunction

endpackage

// File: rtl/mips_tx_fifo.sv
// Console TX FIFO: push side fed by MMIO stores, pop side is a valid/ready stream head.
module mips_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     valid_o,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign valid_o = !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // A pop frees the slot this cycle, so a push into a full FIFO still lands.
  assign pop_ok  = pop_i && valid_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mips_dmem_responder.sv
// Data-side memory responder for the single-cycle MIPS core: word RAM plus LED, switch,
// cycle-counter and console-TX MMIO registers.
module mips_dmem_responder
  import mips_mmio_pkg::*;
#(
  parameter int unsigned RAM_WORDS  = 64,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [7:0]  switches,
  output logic [7:0]  leds,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int unsigned AW   = $clog2(RAM_WORDS);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  mmio_target_e    target;
  logic [AW-1:0]   ram_idx;
  logic            unused_addr;

  logic [31:0]     ram_q [RAM_WORDS];

  logic [7:0]      leds_q, leds_d;
  logic [7:0]      sw_meta_q, sw_meta_d;
  logic [7:0]      sw_sync_q, sw_sync_d;
  logic [31:0]     cyc_q, cyc_d;
  logic [7:0]      drop_q, drop_d;

  logic            tx_push, tx_pop;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;

  assign target      = decode_target(addr[31:16], {addr[7:2], 2'b00});
  assign ram_idx     = addr[2 +: AW];
  assign unused_addr = ^{addr[15:8], addr[1:0]};

  assign tx_push = memwrite && (target == T_TXD);
  assign tx_pop  = tx_valid && tx_ready;

  mips_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (tx_push),
    .data_i  (writedata[7:0]),
    .pop_i   (tx_ready),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .valid_o (tx_valid),
    .data_o  (tx_data),
    .count_o (fifo_count)
  );

  // Data RAM has no reset; aliasing comes from using only the low index bits.
  always_ff @(posedge clk) begin
    if (memwrite && (target == T_RAM)) begin
      ram_q[ram_idx] <= writedata;
    end
  end

  always_comb begin
    leds_d    = leds_q;
    sw_meta_d = switches;
    sw_sync_d = sw_meta_q;
    cyc_d     = cyc_q + 32'd1;
    drop_d    = drop_q;
    if (memwrite && (target == T_LED)) begin
      leds_d = writedata[7:0];
    end
    if (memwrite && (target == T_CYC)) begin
      cyc_d = writedata;
    end
    if (memwrite && (target == T_DROP)) begin
      drop_d = '0;
    end else if (tx_push && fifo_full && !tx_pop && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      leds_q    <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      cyc_q     <= '0;
      drop_q    <= '0;
    end else begin
      leds_q    <= leds_d;
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
      cyc_q     <= cyc_d;
      drop_q    <= drop_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (target)
      T_RAM:   readdata = ram_q[ram_idx];
      T_LED:   readdata = {24'b0, leds_q};
      T_SW:    readdata = {24'b0, sw_sync_q};
      T_CYC:   readdata = cyc_q;
      T_TXS:   readdata = {16'b0, 8'(fifo_count), 6'b0, fifo_empty, fifo_full};
      T_DROP:  readdata = {24'b0, drop_q};
      default: readdata = '0;
    endcase
  end

  assign leds = leds_q;

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Randomised bench for mips_dmem_responder against a behavioural memory/MMIO model.
module tb_mips_dmem_responder;

  localparam int RAM_WORDS  = 64;
  localparam int FIFO_DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwrite = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic [7:0]  switches = 8'h0;
  logic [7:0]  leds;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;

  always #5 clk = ~clk;

  mips_dmem_responder #(
    .RAM_WORDS  (RAM_WORDS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .addr      (addr),
    .writedata (writedata),
    .readdata  (readdata),
    .switches  (switches),
    .leds      (leds),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_ram [RAM_WORDS];
  bit          m_known [RAM_WORDS];
  logic [7:0]  m_leds, m_meta, m_sync, m_drop;
  logic [31:0] m_cyc;
  logic [7:0]  m_q [$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit mdl_read(input logic [31:0] a, output logic [31:0] v);
    int idx;
    v = 32'h0;
    if (a[31:16] != 16'hFFFF) begin
      idx = int'((a >> 2) % RAM_WORDS);
      v = m_ram[idx];
      return m_known[idx];
    end
    case (a[7:0])
      8'h00: v = {24'h0, m_leds};
      8'h04: v = {24'h0, m_sync};
      8'h08: v = m_cyc;
      8'h10: v = {16'h0, 8'(m_q.size()), 6'h0, m_q.size() == 0, m_q.size() == FIFO_DEPTH};
      8'h14: v = {24'h0, m_drop};
      default: v = 32'h0;
    endcase
    return 1'b1;
  endfunction

  task automatic model_tick(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            input logic [7:0] sw, input logic rdy);
    bit mmio, pop, push;
    logic [7:0] ofs;
    mmio = (a[31:16] == 16'hFFFF);
    ofs  = a[7:0];
    pop  = (m_q.size() != 0) && rdy;
    push = we && mmio && (ofs == 8'h0C);
    m_sync = m_meta;
    m_meta = sw;
    if (we && mmio && ofs == 8'h08) m_cyc = wd;
    else m_cyc = m_cyc + 1;
    if (we && mmio && ofs == 8'h00) m_leds = wd[7:0];
    if (we && mmio && ofs == 8'h14) m_drop = 8'h0;
    if (push && m_q.size() == FIFO_DEPTH && !pop) begin
      if (m_drop != 8'hFF) m_drop = m_drop + 1;
      push = 1'b0;
    end
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back(wd[7:0]);
    if (we && !mmio) begin
      m_ram[int'((a >> 2) % RAM_WORDS)]   = wd;
      m_known[int'((a >> 2) % RAM_WORDS)] = 1'b1;
    end
  endtask

  task automatic step_e(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [7:0] sw, input logic rdy,
                        input bit has_exp, input logic [31:0] exp);
    logic [31:0] v;
    memwrite  = we;
    addr      = a;
    writedata = wd;
    switches  = sw;
    tx_ready  = rdy;
    @(negedge clk);
    if (mdl_read(a, v)) check_eq("readdata", readdata, v);
    if (has_exp) check_eq("directed_rd", readdata, exp);
    check_eq("leds", {24'h0, leds}, {24'h0, m_leds});
    check_eq("tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) check_eq("tx_data", {24'h0, tx_data}, {24'h0, m_q[0]});
    @(posedge clk);
    model_tick(we, a, wd, sw, rdy);
    #1;
  endtask

  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [7:0] sw, input logic rdy);
    step_e(we, a, wd, sw, rdy, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    memwrite = 1'b0;
    reset    = 1'b0;
    m_q.delete();
    m_leds = 8'h0;
    m_meta = 8'h0;
    m_sync = 8'h0;
    m_cyc  = 32'h0;
    m_drop = 8'h0;
    #1;
    check_eq("rst_leds", {24'h0, leds}, 32'h0);
    check_eq("rst_tx_valid", 32'(tx_valid), 32'h0);
    check_eq("rst_tx_data", {24'h0, tx_data}, 32'h0);
    addr = 32'hFFFF_0008;
    #1;
    check_eq("rst_cyc", readdata, 32'h0);
    addr = 32'hFFFF_0010;
    #1;
    check_eq("rst_txs", readdata, 32'h0000_0002);
    @(negedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    model_tick(1'b0, addr, writedata, switches, tx_ready);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [7:0]  ofs_tab [10] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h0C, 8'h0C, 8'h10, 8'h14,
                                  8'h18, 8'hFC};
    logic [31:0] a;
    if ($urandom_range(0, 9) < 4) begin
      a = $urandom & 32'hFFFF_FFFC;
      if (a[31:16] == 16'hFFFF) a[31] = 1'b0;
    end else begin
      a = {16'hFFFF, 8'h00, ofs_tab[$urandom_range(0, 9)]};
    end
    return a;
  endfunction

  initial begin
    do_reset();

    // RAM store, readback and aliasing
    step(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 8'h00, 1'b0);
    step_e(1'b0, 32'h0000_0010, 32'h0, 8'h00, 1'b0, 1'b1, 32'hDEAD_BEEF);
    step_e(1'b0, 32'h0000_0010 + 4 * RAM_WORDS, 32'h0, 8'h00, 1'b0, 1'b1, 32'hDEAD_BEEF);

    // LEDs and switch synchroniser latency
    step(1'b1, 32'hFFFF_0000, 32'h0000_01A5, 8'h00, 1'b0);
    step_e(1'b0, 32'hFFFF_0000, 32'h0, 8'h00, 1'b0, 1'b1, 32'h0000_00A5);
    step_e(1'b0, 32'hFFFF_0004, 32'h0, 8'h3C, 1'b0, 1'b1, 32'h0);
    step_e(1'b0, 32'hFFFF_0004, 32'h0, 8'h3C, 1'b0, 1'b1, 32'h0);
    step_e(1'b0, 32'hFFFF_0004, 32'h0, 8'h3C, 1'b0, 1'b1, 32'h0000_003C);

    // Cycle counter load and wrap
    step(1'b1, 32'hFFFF_0008, 32'hFFFF_FFFE, 8'h3C, 1'b0);
    step_e(1'b0, 32'hFFFF_0008, 32'h0, 8'h3C, 1'b0, 1'b1, 32'hFFFF_FFFE);
    step_e(1'b0, 32'hFFFF_0008, 32'h0, 8'h3C, 1'b0, 1'b1, 32'hFFFF_FFFF);
    step_e(1'b0, 32'hFFFF_0008, 32'h0, 8'h3C, 1'b0, 1'b1, 32'h0);

    // Overfill and drain
    do_reset();
    for (int i = 1; i <= 9; i++) step(1'b1, 32'hFFFF_000C, 32'(i), 8'h00, 1'b0);
    step_e(1'b0, 32'hFFFF_0010, 32'h0, 8'h00, 1'b0, 1'b1, 32'h0000_0801);
    step_e(1'b0, 32'hFFFF_0014, 32'h0, 8'h00, 1'b0, 1'b1, 32'h0000_0001);
    for (int i = 1; i <= 8; i++) begin
      check_eq("drain_data", {24'h0, tx_data}, 32'(i));
      step(1'b0, 32'hFFFF_0010, 32'h0, 8'h00, 1'b1);
    end
    check_eq("drain_empty", 32'(tx_valid), 32'h0);

    // Push into full FIFO while popping
    for (int i = 1; i <= 8; i++) step(1'b1, 32'hFFFF_000C, 32'hA0 + 32'(i), 8'h00, 1'b0);
    step(1'b1, 32'hFFFF_000C, 32'h55, 8'h00, 1'b1);
    step_e(1'b0, 32'hFFFF_0010, 32'h0, 8'h00, 1'b0, 1'b1, 32'h0000_0801);
    step_e(1'b0, 32'hFFFF_0014, 32'h0, 8'h00, 1'b0, 1'b1, 32'h0000_0001);
    check_eq("full_pushpop_head", {24'h0, tx_data}, 32'h0000_00A2);

    // Reset while the FIFO holds data
    do_reset();

    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) do_reset();
      step(1'($urandom_range(0, 1)), rand_addr(), $urandom,
           ($urandom_range(0, 7) == 0) ? 8'($urandom) : switches,
           1'($urandom_range(0, 9) < 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
